// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Purpose:
//   Owns the single write port of the register file. After reset, or when
//   clr_req is seen in IDLE, it sweeps every register (0..NREG-1) to CLR_VAL.
//   The sweep takes exactly one write per cycle. Outside a clear it shares the
//   write port between two requesters. Arbitration is round-robin, and each
//   requester uses a req/ack handshake.
//
// Parameters:
//   AW       register address width
//   DW       register data width
//   NREG     number of registers cleared (must be <= 2**AW)
//   CLR_VAL  value written to every register during a clear
//
// Ports:
//   clk       in   1    system clock, all state on posedge
//   reset     in   1    asynchronous active-high reset
//   clr_req   in   1    full-clear request (level, sampled in IDLE)
//   req0      in   1    requester 0 write request (held until ack0)
//   wr0_addr  in   AW   requester 0 write address
//   wr0_data  in   DW   requester 0 write data
//   ack0      out  1    one-cycle grant/completion to requester 0
//   req1      in   1    requester 1 write request (held until ack1)
//   wr1_addr  in   AW   requester 1 write address
//   wr1_data  in   DW   requester 1 write data
//   ack1      out  1    one-cycle grant/completion to requester 1
//   rf_we     out  1    regfile write enable
//   rf_wr     out  AW   regfile write address
//   rf_wdata  out  DW   regfile write data
//   busy      out  1    high while clearing
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int AW      = 4,
    parameter int DW      = 4,
    parameter int NREG    = 16,
    parameter int CLR_VAL = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    input  logic          req0,
    input  logic [AW-1:0] wr0_addr,
    input  logic [DW-1:0] wr0_data,
    output logic          ack0,
    input  logic          req1,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,
    output logic          ack1,
    output logic          rf_we,
    output logic [AW-1:0] rf_wr,
    output logic [DW-1:0] rf_wdata,
    output logic          busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LastAddr = AW'(NREG - 1);
    localparam logic [DW-1:0] ClrVal   = DW'(CLR_VAL);

    state_t        state_q,    state_d;
    logic [AW-1:0] clrCnt_q,   clrCnt_d;
    logic          clrLast_q,  clrLast_d;
    logic          lastGrant_q, lastGrant_d;
    logic          rfWe_q,     rfWe_d;
    logic [AW-1:0] rfWr_q,     rfWr_d;
    logic [DW-1:0] rfWdata_q,  rfWdata_d;
    logic          ack0_q,     ack0_d;
    logic          ack1_q,     ack1_d;
    logic          busy_q,     busy_d;

    logic elig0;
    logic elig1;
    logic pick0;
    logic pick1;

    // A requester acked in this cycle still has req high. That req belongs to
    // the completed transfer, so the requester is masked for one edge.
    // lastGrant_q = 1 means requester 1 won last, so requester 0 wins a tie.
    always_comb begin
        elig0 = req0 & ~ack0_q;
        elig1 = req1 & ~ack1_q;
        pick0 = elig0 & (~elig1 | lastGrant_q);
        pick1 = elig1 & ~pick0;
    end

    // Next-state logic. acks are single-cycle pulses, so they default low
    // every edge. Address and data hold unless a write is issued.
    // clrLast_q marks that the final clear write (NREG-1) has been issued.
    // The counter therefore stops at NREG-1 instead of wrapping, and the
    // following edge ends the clear.
    always_comb begin
        state_d     = state_q;
        clrCnt_d    = clrCnt_q;
        clrLast_d   = clrLast_q;
        lastGrant_d = lastGrant_q;
        rfWe_d      = 1'b0;
        rfWr_d      = rfWr_q;
        rfWdata_d   = rfWdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            CLEAR: begin
                if (clrLast_q) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    rfWe_d    = 1'b1;
                    rfWr_d    = clrCnt_q;
                    rfWdata_d = ClrVal;
                    if (clrCnt_q == LastAddr) begin
                        clrLast_d = 1'b1;
                    end else begin
                        clrCnt_d = clrCnt_q + 1'b1;
                    end
                end
            end

            IDLE: begin
                if (clr_req) begin
                    busy_d    = 1'b1;
                    clrCnt_d  = '0;
                    clrLast_d = 1'b0;
                    state_d   = CLEAR;
                end else if (pick0) begin
                    rfWe_d      = 1'b1;
                    rfWr_d      = wr0_addr;
                    rfWdata_d   = wr0_data;
                    ack0_d      = 1'b1;
                    lastGrant_d = 1'b0;
                end else if (pick1) begin
                    rfWe_d      = 1'b1;
                    rfWr_d      = wr1_addr;
                    rfWdata_d   = wr1_data;
                    ack1_d      = 1'b1;
                    lastGrant_d = 1'b1;
                end
            end

            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // State and output registers. Reset puts the block at the start of a
    // clear, so releasing reset always begins a fresh sweep from address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            clrCnt_q    <= '0;
            clrLast_q   <= 1'b0;
            lastGrant_q <= 1'b1;
            rfWe_q      <= 1'b0;
            rfWr_q      <= '0;
            rfWdata_q   <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clrCnt_q    <= clrCnt_d;
            clrLast_q   <= clrLast_d;
            lastGrant_q <= lastGrant_d;
            rfWe_q      <= rfWe_d;
            rfWr_q      <= rfWr_d;
            rfWdata_q   <= rfWdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
        end
    end

    assign rf_we    = rfWe_q;
    assign rf_wr    = rfWr_q;
    assign rf_wdata = rfWdata_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Directed bench for regfile_wr_arbiter. A small register-file model is
// written from rf_we/rf_wr/rf_wdata so that stored contents can be read back.
// All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 4;
    localparam int NREG = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clrReq;
    logic          req0;
    logic [AW-1:0] wr0Addr;
    logic [DW-1:0] wr0Data;
    logic          ack0;
    logic          req1;
    logic [AW-1:0] wr1Addr;
    logic [DW-1:0] wr1Data;
    logic          ack1;
    logic          rfWe;
    logic [AW-1:0] rfWr;
    logic [DW-1:0] rfWdata;
    logic          busy;

    logic [DW-1:0] mem [NREG];

    int errors = 0;
    int checks = 0;

    regfile_wr_arbiter #(
        .AW(AW), .DW(DW), .NREG(NREG), .CLR_VAL(0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clrReq),
        .req0     (req0),
        .wr0_addr (wr0Addr),
        .wr0_data (wr0Data),
        .ack0     (ack0),
        .req1     (req1),
        .wr1_addr (wr1Addr),
        .wr1_data (wr1Data),
        .ack1     (ack1),
        .rf_we    (rfWe),
        .rf_wr    (rfWr),
        .rf_wdata (rfWdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Register file model: a write commits on the edge after rf_we is seen.
    always @(posedge clk) begin
        if (rfWe) mem[rfWr] <= rfWdata;
    end

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs NREG clear cycles plus the ending edge. When raise1At is non-zero,
    // requester 1 raises req1 after that clear cycle. The request must stay
    // unacked for as long as busy is high.
    task automatic applyStimulus(input string tag, input int raise1At);
        for (int k = 1; k <= NREG; k++) begin
            tick();
            checkOutput({tag, " clr we"},   32'(rfWe),    32'd1);
            checkOutput({tag, " clr addr"}, 32'(rfWr),    32'(k - 1));
            checkOutput({tag, " clr data"}, 32'(rfWdata), 32'd0);
            checkOutput({tag, " clr busy"}, 32'(busy),    32'd1);
            checkOutput({tag, " clr acks"}, 32'({ack0, ack1}), 32'd0);
            if (k == raise1At) begin
                req1    = 1'b1;
                wr1Addr = 4'hC;
                wr1Data = 4'h7;
            end
        end
        tick();
        checkOutput({tag, " end busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " end we"},   32'(rfWe), 32'd0);
        checkOutput({tag, " end acks"}, 32'({ack0, ack1}), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) mem[i] = 4'hF;
        reset   = 1'b1;
        clrReq  = 1'b0;
        req0    = 1'b0;
        wr0Addr = '0;
        wr0Data = '0;
        req1    = 1'b0;
        wr1Addr = '0;
        wr1Data = '0;

        // Reset state
        tick();
        tick();
        checkOutput("rst we",    32'(rfWe),    32'd0);
        checkOutput("rst addr",  32'(rfWr),    32'd0);
        checkOutput("rst data",  32'(rfWdata), 32'd0);
        checkOutput("rst acks",  32'({ack0, ack1}), 32'd0);
        checkOutput("rst busy",  32'(busy),    32'd1);

        // 1: clear after reset release, then readback
        reset = 1'b0;
        applyStimulus("t1", 0);
        for (int i = 0; i < NREG; i++) checkOutput("t1 readback", 32'(mem[i]), 32'd0);

        // 2: single write from requester 0
        req0 = 1'b1; wr0Addr = 4'd5; wr0Data = 4'hA;
        tick();
        checkOutput("t2 we",   32'(rfWe),    32'd1);
        checkOutput("t2 addr", 32'(rfWr),    32'd5);
        checkOutput("t2 data", 32'(rfWdata), 32'hA);
        checkOutput("t2 ack0", 32'(ack0),    32'd1);
        checkOutput("t2 ack1", 32'(ack1),    32'd0);
        req0 = 1'b0;
        tick();
        checkOutput("t2 ack0 drop", 32'(ack0), 32'd0);
        checkOutput("t2 we drop",   32'(rfWe), 32'd0);
        checkOutput("t2 addr hold", 32'(rfWr), 32'd5);
        checkOutput("t2 reg5",      32'(mem[5]), 32'hA);

        // Lone continuous requester: one write every two cycles
        req0 = 1'b1; wr0Addr = 4'd1; wr0Data = 4'h4;
        tick(); checkOutput("lone ack0 c1", 32'(ack0), 32'd1);
        tick(); checkOutput("lone ack0 c2", 32'(ack0), 32'd0);
        tick(); checkOutput("lone ack0 c3", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick(); checkOutput("lone ack0 c4", 32'(ack0), 32'd0);

        // 6: reset pulsed while clearing address 7 restarts the clear
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        checkOutput("t6 pre addr", 32'(rfWr), 32'd7);
        checkOutput("t6 pre we",   32'(rfWe), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6 async we",   32'(rfWe), 32'd0);
        checkOutput("t6 async busy", 32'(busy), 32'd1);
        checkOutput("t6 async addr", 32'(rfWr), 32'd0);
        tick();
        reset = 1'b0;
        applyStimulus("t6", 0);

        // 3: both requesters held right after reset -> 0,1,0,1
        req0 = 1'b1; wr0Addr = 4'd2; wr0Data = 4'h3;
        req1 = 1'b1; wr1Addr = 4'd9; wr1Data = 4'hC;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("t3 we",   32'(rfWe), 32'd1);
            checkOutput("t3 acks", 32'({ack0, ack1}), (c % 2 == 0) ? 32'b10 : 32'b01);
            checkOutput("t3 addr", 32'(rfWr),    (c % 2 == 0) ? 32'd2 : 32'd9);
            checkOutput("t3 data", 32'(rfWdata), (c % 2 == 0) ? 32'h3 : 32'hC);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        checkOutput("t3 acks idle", 32'({ack0, ack1}), 32'd0);
        checkOutput("t3 reg2", 32'(mem[2]), 32'h3);
        checkOutput("t3 reg9", 32'(mem[9]), 32'hC);

        // 4: req1 raised on clear cycle 3 waits for busy to fall
        clrReq = 1'b1;
        tick();
        checkOutput("t4 entry busy", 32'(busy), 32'd1);
        checkOutput("t4 entry we",   32'(rfWe), 32'd0);
        clrReq = 1'b0;
        applyStimulus("t4", 3);
        tick();
        checkOutput("t4 ack1", 32'(ack1),    32'd1);
        checkOutput("t4 we",   32'(rfWe),    32'd1);
        checkOutput("t4 addr", 32'(rfWr),    32'hC);
        checkOutput("t4 data", 32'(rfWdata), 32'h7);
        req1 = 1'b0;
        tick();
        checkOutput("t4 regC", 32'(mem[12]), 32'h7);

        // 5: clr_req and req0 together -> clear wins, then req0 is served
        clrReq = 1'b1;
        req0 = 1'b1; wr0Addr = 4'd5; wr0Data = 4'h6;
        tick();
        checkOutput("t5 entry busy", 32'(busy), 32'd1);
        checkOutput("t5 entry ack0", 32'(ack0), 32'd0);
        checkOutput("t5 entry we",   32'(rfWe), 32'd0);
        clrReq = 1'b0;
        applyStimulus("t5", 0);
        checkOutput("t5 reg5 cleared", 32'(mem[5]), 32'd0);
        tick();
        checkOutput("t5 ack0", 32'(ack0),    32'd1);
        checkOutput("t5 ack1", 32'(ack1),    32'd0);
        checkOutput("t5 addr", 32'(rfWr),    32'd5);
        checkOutput("t5 data", 32'(rfWdata), 32'h6);
        req0 = 1'b0;
        tick();
        checkOutput("t5 reg5", 32'(mem[5]), 32'h6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
